// File: rtl/hwpe_ctrl_tile_seq.sv
// hwpe_ctrl_tile_seq: walks a job of n_tiles_i tiles through the engine, one
// tile at a time (launch pulse, wait for completion), then signals job done.
// Optional watchdog: define HWPE_CTRL_TILE_SEQ_WATCHDOG_EN to abort a tile
// that stays in WAIT for WDOG_CYCLES cycles, raising a sticky err_o.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no job; waiting for start_i
// S_ISSUE  | one-cycle tile_start_o pulse for tile tile_idx_o
// S_WAIT   | tile running; waiting for tile_done_i (or watchdog)
// S_FINISH | one-cycle done_o pulse, then back to idle
module hwpe_ctrl_tile_seq #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] n_tiles_i,
    output logic                 tile_start_o,
    input  logic                 tile_done_i,
    output logic [CNT_WIDTH-1:0] tile_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_idx, w_idx_nxt;
    logic [CNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                 w_last_tile;
    logic                 w_timeout;

    // A watchdog limit of zero cycles has no meaning; reject it at elaboration.
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

    assign w_last_tile = (r_idx == (r_count - CNT_WIDTH'(1)));

`ifdef HWPE_CTRL_TILE_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_err;

    assign w_timeout = (r_wdog == WD_LAST);

    // Cycles spent in WAIT; held at 0 elsewhere so each WAIT entry starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog <= '0;
        end else if (clear_i || (r_state != S_WAIT)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    // Sticky timeout flag; a tile_done_i coinciding with the timeout wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (clear_i || ((r_state == S_IDLE) && start_i)) begin
            r_err <= 1'b0;
        end else if ((r_state == S_WAIT) && !tile_done_i && w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State, tile index and latched tile count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic; clear_i overrides every other input.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_count_nxt = n_tiles_i;
                        w_idx_nxt   = '0;
                        w_state_nxt = (n_tiles_i == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (tile_done_i) begin
                        if (w_last_tile) begin
                            w_state_nxt = S_FINISH;
                        end else begin
                            w_idx_nxt   = r_idx + CNT_WIDTH'(1);
                            w_state_nxt = S_ISSUE;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt = S_FINISH;
                    end
                end
                S_FINISH: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign tile_start_o = (r_state == S_ISSUE);
    assign done_o       = (r_state == S_FINISH);
    assign busy_o       = (r_state != S_IDLE);
    assign tile_idx_o   = r_idx;

endmodule

// File: tb/tb_hwpe_ctrl_tile_seq.sv
// Self-checking bench for hwpe_ctrl_tile_seq. The bench plays the engine: it
// answers each tile launch after a random delay and checks launch order, index,
// pulse timing and job completion against the sequencing rules.
module tb_hwpe_ctrl_tile_seq;

    localparam int CW   = 4;
    localparam int WDOG = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [CW-1:0] n_tiles_i;
    logic          tile_start_o;
    logic          tile_done_i;
    logic [CW-1:0] tile_idx_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int n_tests = 0;
    int n_fail  = 0;

    hwpe_ctrl_tile_seq #(
        .CNT_WIDTH   (CW),
        .WDOG_CYCLES (WDOG)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .n_tiles_i    (n_tiles_i),
        .tile_start_o (tile_start_o),
        .tile_done_i  (tile_done_i),
        .tile_idx_o   (tile_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // One complete job. The engine answers each launch after dmin..dmax idle
    // WAIT cycles. With noise, start_i toggles during WAIT, tile_done_i fires
    // during ISSUE, and n_tiles_i changes after start; none may affect the job.
    task automatic run_job(input int n, input int dmin, input int dmax, input bit noise);
        int d;
        start_i   = 1'b1;
        n_tiles_i = CW'(n);
        @(negedge clk_i);
        start_i   = 1'b0;
        n_tiles_i = noise ? CW'(9) : CW'($urandom);
        if (n == 0) begin
            chk("zero_done",   int'(done_o), 1);
            chk("zero_busy",   int'(busy_o), 1);
            chk("zero_tstart", int'(tile_start_o), 0);
            @(negedge clk_i);
            chk("zero_idle",   int'(busy_o), 0);
            chk("zero_done_1", int'(done_o), 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            chk("tile_start", int'(tile_start_o), 1);
            chk("tile_idx",   int'(tile_idx_o), k);
            chk("tile_busy",  int'(busy_o), 1);
            chk("early_done", int'(done_o), 0);
            if (noise) tile_done_i = 1'b1;
            @(negedge clk_i);
            tile_done_i = 1'b0;
            d = $urandom_range(dmax, dmin);
            for (int j = 0; j < d; j++) begin
                chk("wait_quiet", int'({tile_start_o, done_o}), 0);
                if (noise) start_i = 1'($urandom_range(1, 0));
                @(negedge clk_i);
            end
            start_i     = 1'b0;
            tile_done_i = 1'b1;
            @(negedge clk_i);
            tile_done_i = 1'b0;
        end
        chk("job_done",    int'(done_o), 1);
        chk("job_tstart",  int'(tile_start_o), 0);
        chk("job_last",    int'(tile_idx_o), n - 1);
        chk("job_err",     int'(err_o), 0);
        @(negedge clk_i);
        chk("job_idle",    int'(busy_o), 0);
        chk("job_done_1",  int'(done_o), 0);
        chk("job_idxhold", int'(tile_idx_o), n - 1);
    endtask

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        tile_done_i = 1'b0;
        n_tiles_i   = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy",   int'(busy_o), 0);
        chk("rst_done",   int'(done_o), 0);
        chk("rst_tstart", int'(tile_start_o), 0);
        chk("rst_err",    int'(err_o), 0);
        chk("rst_idx",    int'(tile_idx_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Stray done while idle is ignored.
        tile_done_i = 1'b1;
        @(negedge clk_i);
        tile_done_i = 1'b0;
        chk("idle_stray_done", int'(busy_o), 0);

        run_job(3, 5, 5, 1'b0);
        run_job(0, 0, 0, 1'b0);
        run_job(4, 1, 6, 1'b1);
        run_job((1 << CW) - 1, 0, 2, 1'b0);

        // Soft clear in WAIT of tile 1 of a 5-tile job.
        start_i   = 1'b1;
        n_tiles_i = CW'(5);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        tile_done_i = 1'b1;
        @(negedge clk_i);
        tile_done_i = 1'b0;
        chk("clr_idx1", int'(tile_idx_o), 1);
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clr_busy",   int'(busy_o), 0);
        chk("clr_idx",    int'(tile_idx_o), 0);
        chk("clr_done",   int'(done_o), 0);
        chk("clr_tstart", int'(tile_start_o), 0);
        @(negedge clk_i);
        chk("clr_done_1", int'(done_o), 0);
        run_job(5, 0, 4, 1'b0);

        // Asynchronous reset during ISSUE of tile 2.
        start_i   = 1'b1;
        n_tiles_i = CW'(4);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            tile_done_i = 1'b1;
            @(negedge clk_i);
            tile_done_i = 1'b0;
        end
        chk("ar_tstart_pre", int'(tile_start_o), 1);
        chk("ar_idx_pre",    int'(tile_idx_o), 2);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_tstart", int'(tile_start_o), 0);
        chk("ar_busy",   int'(busy_o), 0);
        chk("ar_done",   int'(done_o), 0);
        chk("ar_idx",    int'(tile_idx_o), 0);
        chk("ar_err",    int'(err_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ar_done_after", int'(done_o), 0);
        run_job(2, 0, 3, 1'b0);

`ifdef HWPE_CTRL_TILE_SEQ_WATCHDOG_EN
        // Withheld tile_done_i: timeout 16 cycles after WAIT entry.
        start_i   = 1'b1;
        n_tiles_i = CW'(2);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < WDOG; i++) begin
            chk("wd_quiet", int'(done_o), 0);
            chk("wd_err_lo", int'(err_o), 0);
            @(negedge clk_i);
        end
        chk("wd_done", int'(done_o), 1);
        chk("wd_err",  int'(err_o), 1);
        chk("wd_idx",  int'(tile_idx_o), 0);
        @(negedge clk_i);
        chk("wd_idle",   int'(busy_o), 0);
        chk("wd_sticky", int'(err_o), 1);
        // Next start clears err_o; tile_done_i exactly at the limit wins.
        run_job(2, WDOG - 1, WDOG - 1, 1'b0);
        run_job(3, WDOG - 2, WDOG - 1, 1'b0);
`else
        // Without the watchdog, WAIT lasts as long as the engine needs.
        run_job(2, 3 * WDOG, 3 * WDOG, 1'b0);
`endif

        for (int r = 0; r < 8; r++) begin
            run_job(int'($urandom_range(8, 0)), 0, 8, 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_tile_seq.md
HWPE_CTRL_TILE_SEQ -- requirements
Module: hwpe_ctrl_tile_seq

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of tile count and index.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024, watchdog limit in cycles per tile; used only with the watchdog compiled in.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous soft clear, driven from the control slave's clear output.
REQ-006 SHALL have port start_i  input  1  one-cycle job start pulse, driven from the control slave's start flag.
REQ-007 SHALL have port n_tiles_i  input  CNT_WIDTH  tiles per job, driven from the register file; sampled on accepted start.
REQ-008 SHALL have port tile_start_o  output  1  one-cycle pulse launching one tile on the engine/streamers.
REQ-009 SHALL have port tile_done_i  input  1  one-cycle pulse, current tile finished.
REQ-010 SHALL have port tile_idx_o  output  CNT_WIDTH  index of the current tile, 0-based.
REQ-011 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done_o  output  1  one-cycle job-complete pulse, feeding the control slave's done input.
REQ-013 SHALL have port err_o  output  1  watchdog timeout flag, sticky.

Function
REQ-014 SHALL implement an FSM with states IDLE, ISSUE, WAIT, FINISH; all outputs are Moore outputs or registered.
REQ-015 IDLE: on start_i, SHALL latch n_tiles_i, set tile_idx to 0, clear err_o, and go to ISSUE; if n_tiles_i==0, SHALL go to FINISH instead.
REQ-016 ISSUE: tile_start_o SHALL be 1 for exactly this one cycle, then go to WAIT.
REQ-017 WAIT: on tile_done_i, if tile_idx == latched count-1, SHALL go to FINISH; otherwise SHALL increment tile_idx and go to ISSUE.
REQ-018 FINISH: done_o SHALL be 1 for exactly one cycle, then go to IDLE; tile_idx_o holds its last value.
REQ-019 Latency: start_i at cycle t SHALL give tile_start_o at t+1; final tile_done_i at cycle t SHALL give done_o at t+1.
REQ-020 start_i outside IDLE SHALL be ignored; tile_done_i outside WAIT SHALL be ignored.
REQ-021 A change of n_tiles_i after start SHALL NOT affect the running job.
REQ-022 Count n_tiles_i = 2^CNT_WIDTH-1 SHALL run all tiles with no index wrap.
REQ-023 clear_i SHALL take priority over all other inputs: next state IDLE, tile_idx 0, err_o 0, no done_o pulse.

Reset
REQ-024 While rst_ni=0, SHALL be in state IDLE, with tile_idx_o=0, latched count=0, tile_start_o=0, busy_o=0, done_o=0, err_o=0, and the watchdog counter at 0.
REQ-025 Reset asserted mid-job SHALL abort the job immediately with no done_o pulse.

Configuration
REQ-026 With macro HWPE_CTRL_TILE_SEQ_WATCHDOG_EN defined, a counter SHALL count cycles in WAIT and restart at 0 on each entry to WAIT.
REQ-027 In that case, if the counter reaches WDOG_CYCLES-1 without tile_done_i, SHALL set err_o=1 and go to FINISH, where done_o pulses.
REQ-028 err_o SHALL stay set until the next accepted start_i, clear_i, or reset.
REQ-029 tile_done_i in the same cycle as the timeout SHALL win, with no error raised.
REQ-030 With the macro undefined, there SHALL be no counter, err_o SHALL be constant 0, and WAIT SHALL last until tile_done_i arrives.

Verification
REQ-031 n_tiles_i=3; start; tile_done_i 5 cycles after each tile_start_o -> 3 tile_start_o pulses with tile_idx_o 0,1,2, one done_o one cycle after the third tile_done_i, busy_o low afterwards.
REQ-032 n_tiles_i=0; start at cycle t -> done_o at t+1, no tile_start_o, busy_o high only during cycle t+1.
REQ-033 n_tiles_i=4; extra start_i pulses during WAIT; n_tiles_i changed to 9 mid-job -> exactly 4 tiles and 1 done_o.
REQ-034 clear_i during WAIT of tile 1 of 5 -> IDLE next cycle, tile_idx_o=0, no done_o; a new start then runs normally.
REQ-035 Watchdog compiled in, WDOG_CYCLES=16, tile_done_i withheld -> err_o=1 and done_o pulse 16 cycles after entering WAIT; err_o cleared by the next start.
REQ-036 rst_ni low during ISSUE of tile 2 -> all outputs 0 asynchronously; after release the block accepts a fresh start.
